// File: rtl/axis_move_scheduler.sv
// Two-axis move scheduler: alternately evaluates theta and phi errors and issues
// timed slow/fast drive slots, each followed by a forced-off settle interval.
// Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
module axis_move_scheduler #(
  parameter logic [15:0] DEADBAND      = 16'd3,
  parameter logic [15:0] FAST_THR      = 16'd20,
  parameter int          MOVE_CYCLES   = 16,
  parameter int          SETTLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sma,
  input  logic [15:0] R_vertical_1,
  input  logic [15:0] R_vertical_2,
  input  logic [15:0] R_horizontal_1,
  input  logic [15:0] R_horizontal_2,
  input  logic [15:0] theta_manual,
  input  logic [15:0] theta_actual,
  input  logic [15:0] phi_manual,
  input  logic [15:0] phi_actual,
  output logic [1:0]  s_out_theta_pos,
  output logic [1:0]  s_out_theta_neg,
  output logic [1:0]  s_out_phi_pos,
  output logic [1:0]  s_out_phi_neg,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [2:0] {
    IDLE, EVAL_T, MOVE_T, SETTLE_T, EVAL_P, MOVE_P, SETTLE_P, FAULT
  } state_t;

  state_t             state, state_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic [1:0]         tp_nxt, tn_nxt, pp_nxt, pn_nxt;
  logic signed [16:0] err;
  logic [16:0]        err_mag;
  logic               in_db, is_fast, stall_hit;
  logic [1:0]         code;

  // Widening to 17 bits keeps full-scale differences (e.g. FFFF - 0) from wrapping.
  function automatic logic signed [16:0] diff17(input logic [15:0] a, input logic [15:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [16:0] mag17(input logic signed [16:0] e);
    return e[16] ? $unsigned(-e) : $unsigned(e);
  endfunction

  always_comb begin
    if (state == EVAL_P)
      err = sma ? diff17(R_horizontal_1, R_horizontal_2) : diff17(phi_manual, phi_actual);
    else
      err = sma ? diff17(R_vertical_1, R_vertical_2) : diff17(theta_manual, theta_actual);
    err_mag = mag17(err);
    in_db   = err_mag <= {1'b0, DEADBAND};
    is_fast = err_mag > {1'b0, FAST_THR};
    code    = is_fast ? 2'b10 : 2'b01;
  end

`ifdef STALL_WATCHDOG_EN
  logic [3:0] stall_t, stall_p, stall_t_nxt, stall_p_nxt;

  assign stall_hit = (state == EVAL_P) ? (stall_p == 4'd8) : (stall_t == 4'd8);
  assign fault     = (state == FAULT);

  // Counts consecutive move slots per axis; only an in-deadband evaluation clears it.
  always_comb begin
    stall_t_nxt = stall_t;
    stall_p_nxt = stall_p;
    if (state == EVAL_T && en) begin
      if (in_db)           stall_t_nxt = 4'd0;
      else if (!stall_hit) stall_t_nxt = stall_t + 4'd1;
    end
    if (state == EVAL_P && en) begin
      if (in_db)           stall_p_nxt = 4'd0;
      else if (!stall_hit) stall_p_nxt = stall_p + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_t <= 4'd0;
      stall_p <= 4'd0;
    end else begin
      stall_t <= stall_t_nxt;
      stall_p <= stall_p_nxt;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign fault     = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tp_nxt    = 2'b00;
    tn_nxt    = 2'b00;
    pp_nxt    = 2'b00;
    pn_nxt    = 2'b00;
    case (state)
      IDLE: if (en) state_nxt = EVAL_T;
      EVAL_T, EVAL_P: begin
        if (!en)
          state_nxt = IDLE;
        else if (in_db)
          state_nxt = (state == EVAL_T) ? EVAL_P : EVAL_T;
        else if (stall_hit)
          state_nxt = FAULT;
        else begin
          cnt_nxt = 16'(MOVE_CYCLES - 1);
          if (state == EVAL_T) begin
            state_nxt = MOVE_T;
            if (err[16]) tn_nxt = code;
            else         tp_nxt = code;
          end else begin
            state_nxt = MOVE_P;
            if (err[16]) pn_nxt = code;
            else         pp_nxt = code;
          end
        end
      end
      MOVE_T, MOVE_P: begin
        if (cnt == 16'd0) begin
          state_nxt = (state == MOVE_T) ? SETTLE_T : SETTLE_P;
          cnt_nxt   = 16'(SETTLE_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - 16'd1;
          tp_nxt  = s_out_theta_pos;
          tn_nxt  = s_out_theta_neg;
          pp_nxt  = s_out_phi_pos;
          pn_nxt  = s_out_phi_neg;
        end
      end
      SETTLE_T: begin
        if (cnt == 16'd0) state_nxt = EVAL_P;
        else              cnt_nxt   = cnt - 16'd1;
      end
      SETTLE_P: begin
        if (cnt == 16'd0) state_nxt = EVAL_T;
        else              cnt_nxt   = cnt - 16'd1;
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= 16'd0;
      s_out_theta_pos <= 2'b00;
      s_out_theta_neg <= 2'b00;
      s_out_phi_pos   <= 2'b00;
      s_out_phi_neg   <= 2'b00;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      s_out_theta_pos <= tp_nxt;
      s_out_theta_neg <= tn_nxt;
      s_out_phi_pos   <= pp_nxt;
      s_out_phi_neg   <= pn_nxt;
    end
  end

endmodule

// File: tb/tb_axis_move_scheduler.sv
// Self-checking bench for axis_move_scheduler; drive runs are scoreboarded as
// (output, code, length, preceding gap) events.
module tb_axis_move_scheduler;
  localparam int MC = 4;
  localparam int SC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, sma;
  logic [15:0] rv1, rv2, rh1, rh2, th_m, th_a, ph_m, ph_a;
  logic [1:0]  tp, tn, pp, pn;
  logic        busy, fault;

  axis_move_scheduler #(
    .DEADBAND(16'd3), .FAST_THR(16'd20), .MOVE_CYCLES(MC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sma(sma),
    .R_vertical_1(rv1), .R_vertical_2(rv2),
    .R_horizontal_1(rh1), .R_horizontal_2(rh2),
    .theta_manual(th_m), .theta_actual(th_a),
    .phi_manual(ph_m), .phi_actual(ph_a),
    .s_out_theta_pos(tp), .s_out_theta_neg(tn),
    .s_out_phi_pos(pp), .s_out_phi_neg(pn),
    .busy(busy), .fault(fault)
  );

  typedef struct {
    int         idx;
    logic [1:0] code;
    int         len;
    int         gap;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  popped = 0;

  // Monitor: tracks runs of a constant nonzero drive and scores each finished run.
  int         run_idx = -1;
  logic [1:0] run_code = 2'b00;
  int         run_len = 0;
  int         run_gap = 0;
  int         gap_cnt = 0;
  logic [1:0] o [4];
  int         nz, ni;
  logic       bad11;
  ev_t        e;

  always @(negedge clk) begin
    o[0] = tp; o[1] = tn; o[2] = pp; o[3] = pn;
    nz = 0; ni = -1; bad11 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o[i] !== 2'b00) begin nz++; ni = i; end
      if (o[i] === 2'b11) bad11 = 1'b1;
    end
    checks++;
    if (nz > 1 || bad11) begin
      errors++;
      $display("FAIL onehot: got tp=%b tn=%b pp=%b pn=%b, need at most one nonzero, none 11", tp, tn, pp, pn);
    end
    if (run_len > 0 && (ni < 0 || ni != run_idx || o[ni] !== run_code)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_drive: got idx=%0d code=%b len=%0d, need no drive", run_idx, run_code, run_len);
      end else begin
        e = exp_q.pop_front();
        popped++;
        if (e.idx != run_idx || e.code !== run_code || e.len != run_len ||
            (e.gap >= 0 && e.gap != run_gap)) begin
          errors++;
          $display("FAIL drive_event: got idx=%0d code=%b len=%0d gap=%0d, need idx=%0d code=%b len=%0d gap=%0d",
                   run_idx, run_code, run_len, run_gap, e.idx, e.code, e.len, e.gap);
        end
      end
      run_len = 0;
    end
    if (ni >= 0) begin
      if (run_len == 0) begin
        run_idx  = ni;
        run_code = o[ni];
        run_gap  = gap_cnt;
        gap_cnt  = 0;
      end
      run_len++;
    end else begin
      gap_cnt++;
    end
  end

  function automatic ev_t mk(input int idx, input logic [1:0] code, input int len, input int gap);
    ev_t r;
    r.idx = idx; r.code = code; r.len = len; r.gap = gap;
    return r;
  endfunction

  task automatic apply_reset();
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drive(input int budget, input string nm);
    int n = 0;
    while ({tp, tn, pp, pn} === 8'h00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({tp, tn, pp, pn} === 8'h00) begin
      errors++;
      $display("FAIL %s: got no drive within %0d cycles, need a drive", nm, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm, output int n);
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got busy=%b after %0d cycles, need 0", nm, busy, budget);
    end
  endtask

  task automatic wait_events(input int target, input int budget, input string nm);
    int n = 0;
    while (popped < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (popped < target) begin
      errors++;
      $display("FAIL %s: got %0d events, need %0d", nm, popped, target);
    end
  endtask

  task automatic check_drained(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending expected drives, need 0", nm, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sma = 1'b0;
    rv1 = 0; rv2 = 0; rh1 = 0; rh2 = 0; th_m = 0; th_a = 0; ph_m = 0; ph_a = 0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tp, tn, pp, pn} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %h, need 00", {tp, tn, pp, pn});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, need 0", busy); end
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b, need 0", fault); end
    apply_reset();
  endtask

  task automatic test_auto_fast();
    int n;
    apply_reset();
    sma = 1'b1; rv1 = 16'd30; rv2 = 16'd5; rh1 = 16'd100; rh2 = 16'd100;
    exp_q.push_back(mk(0, 2'b10, MC, -1));
    exp_q.push_back(mk(0, 2'b10, MC, SC + 2));
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tp !== 2'b00) begin
      errors++; $display("FAIL auto_eval_cycle: got busy=%b tp=%b, need busy=1 tp=00", busy, tp);
    end
    @(negedge clk);
    checks++;
    if (tp !== 2'b10) begin errors++; $display("FAIL auto_first_move: got tp=%b, need 10", tp); end
    wait_events(popped + 1, 40, "auto_move1");
    wait_drive(20, "auto_move2_start");
    en = 1'b0;
    wait_idle(40, "auto_en_drop_idle", n);
    checks++;
    if (n != MC - 1 + SC + 2) begin
      errors++; $display("FAIL auto_en_drop_time: got %0d cycles to idle, need %0d", n, MC - 1 + SC + 2);
    end
    @(negedge clk);
    check_drained("auto_drained");
  endtask

  task automatic test_manual();
    int n;
    apply_reset();
    sma = 1'b0; th_m = 16'd100; th_a = 16'd100; ph_m = 16'd40; ph_a = 16'd30;
    exp_q.push_back(mk(2, 2'b01, MC, -1));
    exp_q.push_back(mk(3, 2'b01, MC, -1));
    en = 1'b1;
    wait_drive(20, "manual_move1_start");
    ph_a = 16'd50;
    wait_events(popped + 1, 40, "manual_move1");
    wait_drive(20, "manual_move2_start");
    en = 1'b0;
    wait_idle(40, "manual_idle", n);
    @(negedge clk);
    check_drained("manual_drained");
  endtask

  task automatic test_thresholds();
    int man [7] = '{103, 104, 120, 121, 100, 65535, 0};
    int act [7] = '{100, 100, 100, 100, 121, 0, 65535};
    int idx [7] = '{-1, 0, 0, 0, 1, 0, 1};
    logic [1:0] cd [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    int n, seen;
    apply_reset();
    sma = 1'b0; ph_m = 16'd7; ph_a = 16'd7;
    for (int k = 0; k < 7; k++) begin
      th_m = 16'(man[k]);
      th_a = 16'(act[k]);
      if (idx[k] >= 0) begin
        exp_q.push_back(mk(idx[k], cd[k], MC, -1));
        en = 1'b1;
        wait_drive(10, "thr_drive_start");
        en = 1'b0;
      end else begin
        seen = 0;
        en = 1'b1;
        repeat (12) begin
          @(negedge clk);
          if ({tp, tn, pp, pn} !== 8'h00) seen++;
        end
        en = 1'b0;
        checks++;
        if (seen != 0) begin
          errors++; $display("FAIL thr_deadband: got %0d driven cycles, need 0", seen);
        end
      end
      wait_idle(40, "thr_idle", n);
      @(negedge clk);
    end
    check_drained("thr_drained");
  endtask

  task automatic test_reset_mid_move();
    apply_reset();
    sma = 1'b0; th_m = 16'd125; th_a = 16'd100; ph_m = 16'd7; ph_a = 16'd7;
    exp_q.push_back(mk(0, 2'b10, 2, -1));
    en = 1'b1;
    wait_drive(10, "rstmid_start");
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({tp, tn, pp, pn} !== 8'h00) begin
      errors++; $display("FAIL rstmid_async: got %h before edge, need 00", {tp, tn, pp, pn});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, need 0", busy); end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_drained("rstmid_drained");
  endtask

  task automatic test_stall();
    int n;
    apply_reset();
    sma = 1'b0; th_m = 16'd125; th_a = 16'd100; ph_m = 16'd7; ph_a = 16'd7;
`ifdef STALL_WATCHDOG_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(0, 2'b10, MC, (k == 0) ? -1 : SC + 2));
    en = 1'b1;
    n = 0;
    while (fault !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fault !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_fault: got fault=%b busy=%b, need 1 1", fault, busy);
    end
    en = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || {tp, tn, pp, pn} !== 8'h00) begin
      errors++; $display("FAIL stall_sticky: got fault=%b outs=%h, need 1 00", fault, {tp, tn, pp, pn});
    end
    check_drained("stall_drained");
    apply_reset();
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b, need 0", fault); end
`else
    for (int k = 0; k < 10; k++) exp_q.push_back(mk(0, 2'b10, MC, (k == 0) ? -1 : SC + 2));
    en = 1'b1;
    wait_events(popped + 10, 300, "stall_continues");
    en = 1'b0;
    wait_idle(40, "stall_idle", n);
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL stall_nofault: got %b, need 0", fault); end
    @(negedge clk);
    check_drained("stall_drained");
`endif
  endtask

  initial begin
    test_reset();
    test_auto_fast();
    test_manual();
    test_thresholds();
    test_reset_mid_move();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000, need completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_move_scheduler.md
AXIS_MOVE_SCHEDULER -- requirements
Module: axis_move_scheduler

Interface
REQ-001 Parameter DEADBAND, 16'd3: error magnitude at or below which an axis is left still.
REQ-002 Parameter FAST_THR, 16'd20: error magnitude above which fast drive is used.
REQ-003 Parameter MOVE_CYCLES, 16: clock cycles one move slot drives a motor.
REQ-004 Parameter SETTLE_CYCLES, 8: clock cycles of forced-off after each move slot.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 en  in  1  scheduler enable.
REQ-008 sma  in  1  mode select; 1 = automatic (sensor tracking), 0 = manual (angle setpoint).
REQ-009 R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2  in  16 each  unsigned light-sensor readings.
REQ-010 theta_manual, theta_actual, phi_manual, phi_actual  in  16 each  unsigned angle setpoint and position.
REQ-011 s_out_theta_pos, s_out_theta_neg, s_out_phi_pos, s_out_phi_neg  out  2 each  registered drive code: 00 off, 01 slow, 10 fast; 11 never driven.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 fault  out  1  sticky stall flag (see Configuration).

Function
REQ-014 FSM states: IDLE, EVAL_T, MOVE_T, SETTLE_T, EVAL_P, MOVE_P, SETTLE_P, FAULT.
REQ-015 IDLE -> EVAL_T when en=1; IDLE otherwise.
REQ-016 EVAL_x lasts exactly 1 cycle; samples sma and the sensor/angle inputs; computes signed 17-bit error.
REQ-017 Theta error: sma=1 -> R_vertical_1 - R_vertical_2; sma=0 -> theta_manual - theta_actual.
REQ-018 Phi error: sma=1 -> R_horizontal_1 - R_horizontal_2; sma=0 -> phi_manual - phi_actual.
REQ-019 |error| <= DEADBAND -> skip to the other axis's EVAL (EVAL_T -> EVAL_P, EVAL_P -> EVAL_T), no drive.
REQ-020 |error| > DEADBAND -> MOVE_x; code = 10 if |error| > FAST_THR, else 01; positive error drives _pos, negative drives _neg.
REQ-021 Drive code latched in EVAL; appears on outputs the first MOVE cycle; held for exactly MOVE_CYCLES cycles.
REQ-022 At most one of the four outputs is nonzero in any cycle; theta and phi never driven simultaneously.
REQ-023 SETTLE_x: all outputs 00 for SETTLE_CYCLES cycles; SETTLE_T -> EVAL_P, SETTLE_P -> EVAL_T.
REQ-024 en sampled only in EVAL states; en=0 there -> IDLE; a move/settle in progress always completes.
REQ-025 sma or input changes during MOVE/SETTLE have no effect until the next EVAL.
REQ-026 Error arithmetic in 17 bits: 16'hFFFF - 16'h0000 must yield +65535, no wrap.
REQ-027 Slot counter 16 bits; reloads on each MOVE/SETTLE entry.

Reset
REQ-028 rst low asynchronously forces IDLE, all four outputs 00, busy 0, fault 0, counters 0, stall counters 0.
REQ-029 rst asserted mid-move kills drive immediately, with no wait for the clock edge.
REQ-030 First EVAL_T occurs the cycle after the first clk edge with rst high and en high.

Configuration
REQ-031 Macro STALL_WATCHDOG_EN defined: per-axis 4-bit counter counts consecutive MOVE slots on that axis; cleared when that axis's EVAL finds |error| <= DEADBAND.
REQ-032 With STALL_WATCHDOG_EN, a counter reaching 8 on entry to a 9th MOVE -> FAULT instead: outputs 00, fault=1, busy=1; exit only by reset.
REQ-033 Without STALL_WATCHDOG_EN: no counters, FAULT unreachable, fault tied 0.

Verification (MOVE_CYCLES=4, SETTLE_CYCLES=2)
REQ-034 sma=1, Rv1=30, Rv2=5, Rh equal, en=1 -> EVAL_T then s_out_theta_pos=10 for 4 cycles, 2 off cycles, EVAL_P skips, theta re-evaluated.
REQ-035 sma=0, phi_manual=40, phi_actual=30, theta matched -> s_out_phi_pos=01 for 4 cycles; phi_actual=50 -> s_out_phi_neg=01.
REQ-036 Error exactly 3 -> no drive; error 4 -> slow; 20 -> slow; 21 -> fast.
REQ-037 rst low in 2nd MOVE cycle -> outputs 00 before the next edge; en=0 mid-move -> move+settle complete, then IDLE, busy=0.
REQ-038 STALL_WATCHDOG_EN, theta error held at 25 -> 8 theta moves, then fault=1, all outputs 00 until rst; macro undefined -> moves continue indefinitely, fault=0.
